// File: rtl/l2_flush_fence_ctrl_pkg.sv
// Shared constants and types for the L2 flush/fence sequencer.
// Holds fence bit positions, flush mode encodings and the sequencer state enum.
package l2_flush_fence_ctrl_pkg;

  localparam int unsigned FENCE_W       = 2;
  localparam int unsigned FENCE_REL_BIT = 1;
  localparam int unsigned FENCE_ACQ_BIT = 0;

  localparam logic FLUSH_ALL = 1'b0;
  localparam logic FLUSH_ACC = 1'b1;

  typedef logic [FENCE_W-1:0] fence_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    F_ISSUE = 3'd1,
    F_WAIT  = 3'd2,
    F_DRAIN = 3'd3,
    X_DRAIN = 3'd4,
    X_INVAL = 3'd5,
    DONE    = 3'd6
  } l2_flush_state_t;

  function automatic logic fence_is_release(input fence_t f);
    return f[FENCE_REL_BIT];
  endfunction

  function automatic logic fence_is_acquire(input fence_t f);
    return f[FENCE_ACQ_BIT];
  endfunction

endpackage

// File: rtl/l2_flush_walker.sv
// Set-major / way-minor (set, way) walker over the L2 geometry.
// Saturates on the last element; clr has priority over incr.
module l2_flush_walker #(
  parameter int unsigned SETS  = 512,
  parameter int unsigned WAYS  = 8,
  parameter int unsigned SET_W = $clog2(SETS),
  parameter int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             incr,
  output logic [SET_W-1:0] set_idx,
  output logic [WAY_W-1:0] way_idx,
  output logic             last
);

  logic way_last;

  assign way_last = (way_idx == WAY_W'(WAYS - 1));
  assign last     = way_last && (set_idx == SET_W'(SETS - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      set_idx <= '0;
      way_idx <= '0;
    end else if (incr && !last) begin
      if (way_last) begin
        way_idx <= '0;
        set_idx <= set_idx + SET_W'(1);
      end else begin
        way_idx <= way_idx + WAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/l2_flush_fence_ctrl.sv
// Flush/fence sequencer for the Spandex L2: walks every (set, way) issuing one
// flush lookup at a time, and sequences release (MSHR drain) / acquire (L1 inval) fences.
module l2_flush_fence_ctrl
  import l2_flush_fence_ctrl_pkg::*;
#(
  parameter int unsigned SETS       = 512,
  parameter int unsigned WAYS       = 8,
  parameter int unsigned MSHR_CNT_W = 3,
  parameter int unsigned SET_W      = $clog2(SETS),
  parameter int unsigned WAY_W      = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_valid,
  input  logic                  flush_mode,
  output logic                  flush_ready,
  input  logic                  fence_valid,
  input  logic [FENCE_W-1:0]    fence_i,
  output logic                  fence_ready,
  input  logic [MSHR_CNT_W-1:0] mshr_cnt,
  output logic                  lookup_valid,
  output logic [SET_W-1:0]      lookup_set,
  output logic [WAY_W-1:0]      lookup_way,
  output logic                  lookup_mode,
  input  logic                  lookup_ready,
  input  logic                  lookup_done,
  input  logic                  lookup_retry,
  output logic                  inval_valid,
  input  logic                  inval_ready,
  output logic                  ongoing_flush,
  output logic                  cpu_req_block,
  output logic                  flush_done,
  output logic                  acc_flush_done,
  output logic                  fence_done
);

  l2_flush_state_t state_q, state_d;
  logic            mode_q;
  logic            op_flush_q;
  logic            acq_q;
  logic            flush_accept;
  logic            fence_accept;
  logic            walk_incr;
  logic            walk_last;
  logic            mshr_empty;

  // Flush wins over a simultaneous fence request.
  assign flush_accept = (state_q == IDLE) && flush_valid;
  assign fence_accept = (state_q == IDLE) && fence_valid && !flush_valid;
  assign mshr_empty   = (mshr_cnt == '0);
  assign lookup_mode  = mode_q;

  l2_flush_walker #(
    .SETS  (SETS),
    .WAYS  (WAYS),
    .SET_W (SET_W),
    .WAY_W (WAY_W)
  ) u_walker (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush_accept),
    .incr    (walk_incr),
    .set_idx (lookup_set),
    .way_idx (lookup_way),
    .last    (walk_last)
  );

  // State and per-operation context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= FLUSH_ALL;
      op_flush_q <= 1'b0;
      acq_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush_accept) begin
        mode_q     <= flush_mode;
        op_flush_q <= 1'b1;
      end else if (fence_accept) begin
        op_flush_q <= 1'b0;
        acq_q      <= fence_is_acquire(fence_i);
      end
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d        = state_q;
    walk_incr      = 1'b0;
    flush_ready    = 1'b0;
    fence_ready    = 1'b0;
    lookup_valid   = 1'b0;
    inval_valid    = 1'b0;
    ongoing_flush  = 1'b0;
    cpu_req_block  = 1'b1;
    flush_done     = 1'b0;
    acc_flush_done = 1'b0;
    fence_done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cpu_req_block = 1'b0;
        flush_ready   = 1'b1;
        fence_ready   = !flush_valid;
        if (flush_valid) begin
          state_d = F_ISSUE;
        end else if (fence_valid) begin
          if (fence_is_release(fence_i))      state_d = X_DRAIN;
          else if (fence_is_acquire(fence_i)) state_d = X_INVAL;
          else                                state_d = DONE;
        end
      end
      F_ISSUE: begin
        ongoing_flush = 1'b1;
        lookup_valid  = 1'b1;
        if (lookup_ready) state_d = F_WAIT;
      end
      F_WAIT: begin
        ongoing_flush = 1'b1;
        if (lookup_done) begin
          if (lookup_retry) begin
            state_d = F_ISSUE;
          end else if (walk_last) begin
            state_d = F_DRAIN;
          end else begin
            walk_incr = 1'b1;
            state_d   = F_ISSUE;
          end
        end
      end
      F_DRAIN: begin
        ongoing_flush = 1'b1;
        if (mshr_empty) state_d = DONE;
      end
      X_DRAIN: begin
        if (mshr_empty) state_d = acq_q ? X_INVAL : DONE;
      end
      X_INVAL: begin
        inval_valid = 1'b1;
        if (inval_ready) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (!op_flush_q)             fence_done     = 1'b1;
        else if (mode_q == FLUSH_ACC) acc_flush_done = 1'b1;
        else                          flush_done     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_flush_fence_ctrl.sv
// Randomized self-checking bench for l2_flush_fence_ctrl on a 4x2 geometry.
// Expected lookups, pulses and latencies come from a transaction-level model of the walk.
module tb_l2_flush_fence_ctrl;
  import l2_flush_fence_ctrl_pkg::*;

  localparam int unsigned SETS       = 4;
  localparam int unsigned WAYS       = 2;
  localparam int unsigned MSHR_CNT_W = 3;
  localparam int unsigned SET_W      = 2;
  localparam int unsigned WAY_W      = 1;
  localparam int          N          = SETS * WAYS;

  logic                  clk;
  logic                  rst;
  logic                  flush_valid;
  logic                  flush_mode;
  logic                  flush_ready;
  logic                  fence_valid;
  logic [1:0]            fence_i;
  logic                  fence_ready;
  logic [MSHR_CNT_W-1:0] mshr_cnt;
  logic                  lookup_valid;
  logic [SET_W-1:0]      lookup_set;
  logic [WAY_W-1:0]      lookup_way;
  logic                  lookup_mode;
  logic                  lookup_ready;
  logic                  lookup_done;
  logic                  lookup_retry;
  logic                  inval_valid;
  logic                  inval_ready;
  logic                  ongoing_flush;
  logic                  cpu_req_block;
  logic                  flush_done;
  logic                  acc_flush_done;
  logic                  fence_done;

  int checks   = 0;
  int failures = 0;

  l2_flush_fence_ctrl #(
    .SETS       (SETS),
    .WAYS       (WAYS),
    .MSHR_CNT_W (MSHR_CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_valid    (flush_valid),
    .flush_mode     (flush_mode),
    .flush_ready    (flush_ready),
    .fence_valid    (fence_valid),
    .fence_i        (fence_i),
    .fence_ready    (fence_ready),
    .mshr_cnt       (mshr_cnt),
    .lookup_valid   (lookup_valid),
    .lookup_set     (lookup_set),
    .lookup_way     (lookup_way),
    .lookup_mode    (lookup_mode),
    .lookup_ready   (lookup_ready),
    .lookup_done    (lookup_done),
    .lookup_retry   (lookup_retry),
    .inval_valid    (inval_valid),
    .inval_ready    (inval_ready),
    .ongoing_flush  (ongoing_flush),
    .cpu_req_block  (cpu_req_block),
    .flush_done     (flush_done),
    .acc_flush_done (acc_flush_done),
    .fence_done     (fence_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  function automatic logic [2:0] pulses();
    return {flush_done, acc_flush_done, fence_done};
  endfunction

  // Any non-IDLE, non-DONE cycle: blocked, not ready, no pulses.
  task automatic check_busy(input string tag, input logic exp_lv, input logic exp_ongoing,
                            input logic exp_inval);
    check_eq({tag, "_lookup_valid"}, 32'(lookup_valid), 32'(exp_lv));
    check_eq({tag, "_ongoing"}, 32'(ongoing_flush), 32'(exp_ongoing));
    check_eq({tag, "_inval_valid"}, 32'(inval_valid), 32'(exp_inval));
    check_eq({tag, "_cpu_block"}, 32'(cpu_req_block), 32'd1);
    check_eq({tag, "_readies"}, 32'({flush_ready, fence_ready}), 32'd0);
    check_eq({tag, "_pulses"}, 32'(pulses()), 32'd0);
  endtask

  task automatic check_idle(input string tag, input logic exp_fence_ready);
    check_eq({tag, "_flush_ready"}, 32'(flush_ready), 32'd1);
    check_eq({tag, "_fence_ready"}, 32'(fence_ready), 32'(exp_fence_ready));
    check_eq({tag, "_cpu_block"}, 32'(cpu_req_block), 32'd0);
    check_eq({tag, "_ongoing"}, 32'(ongoing_flush), 32'd0);
    check_eq({tag, "_lookup_valid"}, 32'(lookup_valid), 32'd0);
    check_eq({tag, "_inval_valid"}, 32'(inval_valid), 32'd0);
    check_eq({tag, "_pulses"}, 32'(pulses()), 32'd0);
  endtask

  task automatic clear_inputs();
    flush_valid  = 1'b0;
    flush_mode   = 1'b0;
    fence_valid  = 1'b0;
    fence_i      = 2'b00;
    mshr_cnt     = '0;
    lookup_ready = 1'b0;
    lookup_done  = 1'b0;
    lookup_retry = 1'b0;
    inval_ready  = 1'b0;
  endtask

  // One flush operation. force_retry_hs: handshake index whose done carries retry.
  // abort_idx >= 0: pulse rst while waiting on that element and stop.
  task automatic run_flush(input logic mode, input int ready_pct, input int retry_pct,
                           input int force_retry_hs, input int max_dly, input int drain,
                           input logic with_fence, input int abort_idx, input logic check_lat);
    int   idx;
    int   dly;
    int   cyc;
    int   hs_cnt;
    int   retries;
    logic issuing;
    idx = 0; dly = 0; cyc = 0; hs_cnt = 0; retries = 0; issuing = 1'b1;

    @(negedge clk);
    clear_inputs();
    flush_valid = 1'b1;
    flush_mode  = mode;
    fence_valid = with_fence;
    fence_i     = 2'b11;
    mshr_cnt    = MSHR_CNT_W'($urandom);
    #1;
    check_eq("flush_accept_ready", 32'(flush_ready), 32'd1);
    check_eq("fence_ready_flush_wins", 32'(fence_ready), 32'd0);
    check_eq("accept_cpu_block", 32'(cpu_req_block), 32'd0);

    while (idx < N && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      flush_valid  = 1'b0;
      flush_mode   = 1'($urandom);
      mshr_cnt     = MSHR_CNT_W'($urandom);
      lookup_ready = 1'b0;
      lookup_done  = 1'b0;
      lookup_retry = 1'($urandom);
      if (!issuing && abort_idx >= 0 && idx == abort_idx) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        #1;
        check_idle("after_rst", 1'b1);
        check_eq("after_rst_set", 32'(lookup_set), 32'd0);
        check_eq("after_rst_way", 32'(lookup_way), 32'd0);
        check_eq("after_rst_mode", 32'(lookup_mode), 32'd0);
        return;
      end
      if (issuing) begin
        lookup_ready = pct(ready_pct);
        lookup_done  = ($urandom_range(3, 0) == 0);
      end else if (dly > 0) begin
        dly--;
      end else begin
        lookup_done  = 1'b1;
        lookup_retry = (hs_cnt - 1 == force_retry_hs) ? 1'b1 : pct(retry_pct);
      end
      #1;
      check_busy("walk", issuing, 1'b1, 1'b0);
      if (issuing) begin
        check_eq("lookup_set", 32'(lookup_set), 32'(idx / WAYS));
        check_eq("lookup_way", 32'(lookup_way), 32'(idx % WAYS));
        check_eq("lookup_mode", 32'(lookup_mode), 32'(mode));
      end
      if (issuing && lookup_ready) begin
        issuing = 1'b0;
        hs_cnt++;
        dly = int'($urandom_range(max_dly, 0));
      end else if (!issuing && lookup_done) begin
        if (lookup_retry) retries++;
        else              idx++;
        issuing = 1'b1;
      end
    end
    check_eq("walk_complete", 32'(idx), 32'(N));
    check_eq("lookup_count", 32'(hs_cnt), 32'(N + retries));

    for (int k = 0; k < drain; k++) begin
      @(negedge clk);
      cyc++;
      lookup_done = 1'($urandom);
      mshr_cnt    = MSHR_CNT_W'($urandom_range(7, 1));
      #1;
      check_busy("f_drain", 1'b0, 1'b1, 1'b0);
    end
    @(negedge clk);
    cyc++;
    lookup_done = 1'b0;
    mshr_cnt    = '0;
    #1;
    check_busy("f_drain_last", 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    cyc++;
    mshr_cnt = MSHR_CNT_W'($urandom);
    #1;
    check_eq("flush_pulse", 32'(pulses()), (mode == FLUSH_ACC) ? 32'd2 : 32'd4);
    check_eq("done_ongoing", 32'(ongoing_flush), 32'd0);
    check_eq("done_cpu_block", 32'(cpu_req_block), 32'd1);
    check_eq("done_readies", 32'({flush_ready, fence_ready}), 32'd0);
    if (check_lat) check_eq("flush_latency", 32'(cyc), 32'(2 * N + 2));

    if (!with_fence) begin
      @(negedge clk);
      clear_inputs();
      #1;
      check_idle("post_flush", 1'b1);
    end
  endtask

  // One fence operation, accepted in the first cycle.
  task automatic run_fence(input logic [1:0] fi, input int drain, input int inval_dly);
    @(negedge clk);
    clear_inputs();
    fence_valid = 1'b1;
    fence_i     = fi;
    mshr_cnt    = MSHR_CNT_W'($urandom);
    #1;
    check_idle("fence_accept", 1'b1);

    if (fi[FENCE_REL_BIT]) begin
      for (int k = 0; k < drain; k++) begin
        @(negedge clk);
        clear_inputs();
        mshr_cnt = MSHR_CNT_W'($urandom_range(7, 1));
        inval_ready = 1'($urandom);
        #1;
        check_busy("x_drain", 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      clear_inputs();
      inval_ready = 1'($urandom);
      #1;
      check_busy("x_drain_last", 1'b0, 1'b0, 1'b0);
    end

    if (fi[FENCE_ACQ_BIT]) begin
      for (int k = 0; k < inval_dly; k++) begin
        @(negedge clk);
        clear_inputs();
        mshr_cnt = MSHR_CNT_W'($urandom);
        #1;
        check_busy("x_inval_wait", 1'b0, 1'b0, 1'b1);
      end
      @(negedge clk);
      clear_inputs();
      inval_ready = 1'b1;
      #1;
      check_busy("x_inval_hs", 1'b0, 1'b0, 1'b1);
    end

    @(negedge clk);
    clear_inputs();
    #1;
    check_eq("fence_pulse", 32'(pulses()), 32'd1);
    check_eq("fence_done_cpu_block", 32'(cpu_req_block), 32'd1);
    check_eq("fence_done_inval", 32'(inval_valid), 32'd0);

    @(negedge clk);
    #1;
    check_idle("post_fence", 1'b1);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset", 1'b1);
    check_eq("reset_set", 32'(lookup_set), 32'd0);
    check_eq("reset_way", 32'(lookup_way), 32'd0);
    check_eq("reset_mode", 32'(lookup_mode), 32'd0);
    rst = 1'b0;

    // Zero-stall mode-0 flush with exact latency.
    run_flush(FLUSH_ALL, 100, 0, -1, 0, 0, 1'b0, -1, 1'b1);
    // Mode-1 flush, one retry on the third lookup.
    run_flush(FLUSH_ACC, 100, 0, 2, 0, 0, 1'b0, -1, 1'b0);
    // Flush with MSHRs draining for 5 cycles.
    run_flush(FLUSH_ALL, 100, 0, -1, 0, 5, 1'b0, -1, 1'b0);
    // Release+acquire fence with drain and delayed inval_ready.
    run_fence(2'b11, 3, 4);
    // Simultaneous flush and fence: fence follows after the flush.
    run_flush(FLUSH_ALL, 100, 0, -1, 0, 0, 1'b1, -1, 1'b0);
    run_fence(2'b11, 0, 0);
    // Reset while waiting at set 2, then a clean restart.
    run_flush(FLUSH_ACC, 100, 0, -1, 1, 0, 1'b0, 4, 1'b0);
    run_flush(FLUSH_ALL, 100, 0, -1, 0, 0, 1'b0, -1, 1'b1);
    run_fence(2'b10, 2, 0);
    run_fence(2'b01, 0, 2);
    run_fence(2'b00, 0, 0);

    for (int it = 0; it < 20; it++) begin
      if (pct(60)) begin
        run_flush(1'($urandom), int'($urandom_range(100, 30)), int'($urandom_range(40, 0)), -1,
                  int'($urandom_range(3, 0)), int'($urandom_range(4, 0)), 1'b0, -1, 1'b0);
      end else begin
        run_fence(2'($urandom), int'($urandom_range(4, 0)), int'($urandom_range(4, 0)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
